// File: rtl/alu_iter_exec_if.sv
// Request/response bundle between pipeline control and the execute-stage ALU.
// master = pipeline control (drives requests), slave = ALU.
interface alu_iter_exec_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               start_i;
  logic [3:0]         ctrl_i;
  logic [DATA_W-1:0]  src1_i;
  logic [DATA_W-1:0]  src2_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic [DATA_W-1:0]  result_o;
  logic               zero_o;
  logic               busy_o;
  logic               done_o;
  logic               illegal_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i, shamt_i,
    input  result_o, zero_o, busy_o, done_o, illegal_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i, shamt_i,
    output result_o, zero_o, busy_o, done_o, illegal_o
  );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with start/busy/done handshake; single-cycle ops plus an
// optional iterative shift-add multiply compiled in with `define ALU_MUL_EN.
module alu_iter_exec #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input logic            clk_i,
   input logic            rst_i,
   alu_iter_exec_if.slave bus
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SLLV = 4'b1010;
   localparam logic [3:0] OP_SRLV = 4'b1011;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'b1100;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_EXEC} state_e;
`endif

   state_e             state;
   logic [3:0]         ctrl_q;
   logic [DATA_W-1:0]  src1_q;
   logic [DATA_W-1:0]  src2_q;
   logic [SHAMT_W-1:0] shamt_q;
   logic [DATA_W-1:0]  exec_res;
   logic               exec_ill;
   logic               accept;

`ifdef ALU_MUL_EN
   logic [DATA_W-1:0]  mcand;
   logic [DATA_W-1:0]  mplier;
   logic [DATA_W-1:0]  acc;
   logic [DATA_W-1:0]  acc_next;
   logic [SHAMT_W-1:0] mul_cnt;

   assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

   assign accept = (state == S_IDLE) && bus.start_i;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      exec_res = '0;
      exec_ill = 1'b0;
      case (ctrl_q)
         OP_AND:  exec_res = src1_q & src2_q;
         OP_OR:   exec_res = src1_q | src2_q;
         OP_ADD:  exec_res = src1_q + src2_q;
         OP_SUB:  exec_res = src1_q - src2_q;
         OP_SLT:  exec_res = {{(DATA_W-1){1'b0}}, ($signed(src1_q) < $signed(src2_q))};
         OP_SLL:  exec_res = src2_q << shamt_q;
         OP_SRL:  exec_res = src2_q >> shamt_q;
         OP_SLLV: exec_res = src2_q << src1_q[SHAMT_W-1:0];
         OP_SRLV: exec_res = src2_q >> src1_q[SHAMT_W-1:0];
         default: exec_ill = 1'b1;
      endcase
   end

   // NOTE: operand/datapath registers carry no reset; the control FSM guarantees
   // they are written on acceptance before anything reads them.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         ctrl_q  <= bus.ctrl_i;
         src1_q  <= bus.src1_i;
         src2_q  <= bus.src2_i;
         shamt_q <= bus.shamt_i;
`ifdef ALU_MUL_EN
         mcand   <= bus.src1_i;
         mplier  <= bus.src2_i;
         acc     <= '0;
`endif
      end
`ifdef ALU_MUL_EN
      else if (state == S_MUL) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= S_IDLE;
         bus.result_o  <= '0;
         bus.zero_o    <= 1'b1;
         bus.busy_o    <= 1'b0;
         bus.done_o    <= 1'b0;
         bus.illegal_o <= 1'b0;
`ifdef ALU_MUL_EN
         mul_cnt       <= '0;
`endif
      end else begin
         bus.done_o    <= 1'b0;
         bus.illegal_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start_i) begin
                  bus.busy_o <= 1'b1;
`ifdef ALU_MUL_EN
                  if (bus.ctrl_i == OP_MUL) begin
                     state   <= S_MUL;
                     mul_cnt <= '0;
                  end else begin
                     state   <= S_EXEC;
                  end
`else
                  state <= S_EXEC;
`endif
               end
            end
            S_EXEC: begin
               bus.result_o  <= exec_res;
               bus.zero_o    <= (exec_res == '0);
               bus.illegal_o <= exec_ill;
               bus.done_o    <= 1'b1;
               bus.busy_o    <= 1'b0;
               state         <= S_IDLE;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
               mul_cnt <= mul_cnt + 1'b1;
               // Last step folds its partial product straight into the result.
               if (mul_cnt == SHAMT_W'(DATA_W - 1)) begin
                  bus.result_o <= acc_next;
                  bus.zero_o   <= (acc_next == '0);
                  bus.done_o   <= 1'b1;
                  bus.busy_o   <= 1'b0;
                  state        <= S_IDLE;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
